// File: rtl/elev_ctrl_if.sv
// Car panel / actuator bundle for the four-floor elevator controller.
// The controller is the slave: it consumes buttons and drives position and door.
interface elev_ctrl_if;
    logic [3:0] floorBtn;
    logic [1:0] floorSel;
    logic       door;

    modport master (output floorBtn, input floorSel, input door);
    modport slave  (input floorBtn, output floorSel, output door);
endinterface

// File: rtl/elev_ctrl.sv
// Four-floor elevator controller: Moore FSM (IDLE/CLOSE/MOVE) with a latched
// target floor; car moves one floor per clock, door closes one cycle before moving.
module elev_ctrl (
    input  logic              clk,
    input  logic              rst,
    elev_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLOSE = 2'd1,
        MOVE  = 2'd2
    } state_t;

    state_t     stateReg, stateNext;
    logic [1:0] floorSelReg, floorSelNext;
    logic [1:0] targetReg, targetNext;
    logic       doorReg, doorNext;

    // Buttons for every floor except the one the car is already at.
    logic [3:0] reqMask;
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign reqMask[gi] = bus.floorBtn[gi] && (floorSelReg != 2'(gi));
    end

    logic       hasCand;
    logic [1:0] cand;
    logic [1:0] stepFloor;

    always_comb begin
        hasCand = 1'b0;
        cand    = 2'd0;
        // Scan high to low so the lowest-indexed request wins.
        for (int i = 3; i >= 0; i--) begin
            if (reqMask[i]) begin
                hasCand = 1'b1;
                cand    = 2'(i);
            end
        end
    end

    assign stepFloor = (targetReg > floorSelReg) ? floorSelReg + 2'd1
                                                 : floorSelReg - 2'd1;

    always_comb begin
        stateNext    = stateReg;
        floorSelNext = floorSelReg;
        targetNext   = targetReg;
        doorNext     = doorReg;
        unique case (stateReg)
            IDLE: begin
                doorNext = 1'b1;
                if (hasCand) begin
                    targetNext = cand;
                    doorNext   = 1'b0;
                    stateNext  = CLOSE;
                end
            end
            CLOSE: begin
                doorNext     = 1'b0;
                floorSelNext = stepFloor;
                stateNext    = MOVE;
            end
            MOVE: begin
                if (floorSelReg != targetReg) begin
                    floorSelNext = stepFloor;
                    doorNext     = 1'b0;
                end else begin
                    doorNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                doorNext  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= IDLE;
            floorSelReg <= 2'd0;
            targetReg   <= 2'd0;
            doorReg     <= 1'b1;
        end else begin
            stateReg    <= stateNext;
            floorSelReg <= floorSelNext;
            targetReg   <= targetNext;
            doorReg     <= doorNext;
        end
    end

    assign bus.floorSel = floorSelReg;
    assign bus.door     = doorReg;

endmodule

// File: tb/tb_elev_ctrl.sv
// Bench for elev_ctrl: trip-plan reference model checked every cycle, plus
// directed per-cycle literal expectations for each scenario.
module tb_elev_ctrl;

    logic clk;
    logic rst;
    elev_ctrl_if ifc ();

    elev_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    // Reference model: when idle, a sampled request expands into the whole
    // planned sequence of (floor, door) outputs; the plan is replayed edge by edge.
    logic [1:0] expF = 2'd0;
    logic       expD = 1'b1;
    logic [2:0] plan[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            plan.delete();
            expF = 2'd0;
            expD = 1'b1;
        end else if (plan.size() > 0) begin
            {expF, expD} = plan.pop_front();
        end else begin
            int tgt;
            tgt = -1;
            for (int i = 3; i >= 0; i--)
                if (ifc.floorBtn[i] && i != int'(expF)) tgt = i;
            if (tgt >= 0) begin
                int cur;
                int dir;
                cur = int'(expF);
                dir = (tgt > cur) ? 1 : -1;
                for (int f = cur + dir; f != tgt + dir; f += dir)
                    plan.push_back({2'(f), 1'b0});
                plan.push_back({2'(tgt), 1'b1});
                expD = 1'b0;
            end else begin
                expD = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        tests++;
        if (ifc.floorSel !== expF || ifc.door !== expD) begin
            errors++;
            $display("FAIL model t=%0t got floorSel=%0d door=%0b want floorSel=%0d door=%0b",
                     $time, ifc.floorSel, ifc.door, expF, expD);
        end
    end

    task automatic chk(input logic [1:0] f, input logic d, input string name);
        tests++;
        if (ifc.floorSel !== f || ifc.door !== d) begin
            errors++;
            $display("FAIL %s got (%0d,%0b) want (%0d,%0b)", name, ifc.floorSel, ifc.door, f, d);
        end else begin
            $display("[TB] %s (%0d,%0b) ok", name, f, d);
        end
    endtask

    task automatic step(input logic [1:0] f, input logic d, input string name);
        @(negedge clk);
        chk(f, d, name);
    endtask

    initial begin
        rst = 1'b0;
        ifc.floorBtn = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk(2'd0, 1'b1, "reset");
        rst = 1'b1;

        // Reset then request floor 1
        ifc.floorBtn = 4'b0010;
        step(2'd0, 1'b0, "r1_close");
        step(2'd1, 1'b0, "r1_move");
        step(2'd1, 1'b1, "r1_open");
        step(2'd1, 1'b1, "hold_own_btn");
        step(2'd1, 1'b1, "hold_own_btn2");
        ifc.floorBtn = 4'b0000;
        step(2'd1, 1'b1, "idle_nobtn");
        step(2'd1, 1'b1, "idle_nobtn2");

        // Back to ground
        ifc.floorBtn = 4'b0001;
        step(2'd1, 1'b0, "to0_close");
        step(2'd0, 1'b0, "to0_move");
        step(2'd0, 1'b1, "to0_open");

        // Full climb, then descent requested on the arrival cycle
        ifc.floorBtn = 4'b1000;
        step(2'd0, 1'b0, "up_close");
        step(2'd1, 1'b0, "up_f1");
        step(2'd2, 1'b0, "up_f2");
        step(2'd3, 1'b0, "up_f3");
        step(2'd3, 1'b1, "up_open");
        ifc.floorBtn = 4'b0001;
        step(2'd3, 1'b0, "dn_close");
        step(2'd2, 1'b0, "dn_f2");
        step(2'd1, 1'b0, "dn_f1");
        step(2'd0, 1'b0, "dn_f0");
        step(2'd0, 1'b1, "dn_open");

        // Short hops 0->1->2->3->2
        ifc.floorBtn = 4'b0010;
        step(2'd0, 1'b0, "h01_close");
        step(2'd1, 1'b0, "h01_f1");
        step(2'd1, 1'b1, "h01_open");
        ifc.floorBtn = 4'b0100;
        step(2'd1, 1'b0, "h12_close");
        step(2'd2, 1'b0, "h12_f2");
        step(2'd2, 1'b1, "h12_open");
        ifc.floorBtn = 4'b1000;
        step(2'd2, 1'b0, "h23_close");
        step(2'd3, 1'b0, "h23_f3");
        step(2'd3, 1'b1, "h23_open");
        ifc.floorBtn = 4'b0100;
        step(2'd3, 1'b0, "h32_close");
        step(2'd2, 1'b0, "h32_f2");
        step(2'd2, 1'b1, "h32_open");

        // Priority: floors 0,2,3 pressed at floor 2 -> lowest (0) wins
        ifc.floorBtn = 4'b1101;
        step(2'd2, 1'b0, "pri_close");
        ifc.floorBtn = 4'b0000;
        step(2'd1, 1'b0, "pri_f1");
        step(2'd0, 1'b0, "pri_f0");
        step(2'd0, 1'b1, "pri_open");

        // Target latching: button changed after CLOSE must not redirect
        ifc.floorBtn = 4'b1000;
        step(2'd0, 1'b0, "latch_close");
        ifc.floorBtn = 4'b0010;
        step(2'd1, 1'b0, "latch_f1");
        step(2'd2, 1'b0, "latch_f2");
        step(2'd3, 1'b0, "latch_f3");
        step(2'd3, 1'b1, "latch_open");
        ifc.floorBtn = 4'b0000;
        step(2'd3, 1'b1, "latch_idle");

        // Back to ground, then async reset mid-trip
        ifc.floorBtn = 4'b0001;
        step(2'd3, 1'b0, "ret_close");
        ifc.floorBtn = 4'b0000;
        step(2'd2, 1'b0, "ret_f2");
        step(2'd1, 1'b0, "ret_f1");
        step(2'd0, 1'b0, "ret_f0");
        step(2'd0, 1'b1, "ret_open");
        ifc.floorBtn = 4'b1000;
        step(2'd0, 1'b0, "ar_close");
        ifc.floorBtn = 4'b0000;
        step(2'd1, 1'b0, "ar_f1");
        step(2'd2, 1'b0, "ar_f2");
        #2 rst = 1'b0;
        #1 chk(2'd0, 1'b1, "async_rst");
        #1 rst = 1'b1;
        step(2'd0, 1'b1, "post_rst1");
        step(2'd0, 1'b1, "post_rst2");
        step(2'd0, 1'b1, "post_rst3");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
